// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_pkg                                                    |
// | Description : Shared symbol codes, ASCII constants and the decoder FSM     |
// |               state encoding for the Morse stream decoder.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package morse_pkg;

  // Symbol codes carried on sym_code
  localparam logic [1:0] SYM_DOT  = 2'b10;
  localparam logic [1:0] SYM_DASH = 2'b11;
  localparam logic [1:0] SYM_LGAP = 2'b00;
  localparam logic [1:0] SYM_WGAP = 2'b01;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  typedef enum logic [1:0] {
    ST_COLLECT    = 2'd0,
    ST_EMIT_CHAR  = 2'd1,
    ST_EMIT_SPACE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/morse_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_lut                                                    |
// | Description : Combinational Morse-to-ASCII lookup (A-Z, 0-9).              |
// |               Code is five 2-bit symbols, first symbol in the MSBs,        |
// |               unused slots 00. Unknown codes give err=1, ascii=8'h00.      |
// | Ports       : code  [9:0] in  - packed symbol code                         |
// |               ascii [7:0] out - decoded character                          |
// |               err         out - code is not a known letter/digit           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_lut
  import morse_pkg::*;
(
  input  logic [9:0] code,
  output logic [7:0] ascii,
  output logic       err
);

  always_comb begin
    ascii = ASCII_NUL;
    err   = 1'b0;
    case (code)
      10'b10_11_00_00_00: ascii = 8'h41; // A .-
      10'b11_10_10_10_00: ascii = 8'h42; // B -...
      10'b11_10_11_10_00: ascii = 8'h43; // C -.-.
      10'b11_10_10_00_00: ascii = 8'h44; // D -..
      10'b10_00_00_00_00: ascii = 8'h45; // E .
      10'b10_10_11_10_00: ascii = 8'h46; // F ..-.
      10'b11_11_10_00_00: ascii = 8'h47; // G --.
      10'b10_10_10_10_00: ascii = 8'h48; // H ....
      10'b10_10_00_00_00: ascii = 8'h49; // I ..
      10'b10_11_11_11_00: ascii = 8'h4A; // J .---
      10'b11_10_11_00_00: ascii = 8'h4B; // K -.-
      10'b10_11_10_10_00: ascii = 8'h4C; // L .-..
      10'b11_11_00_00_00: ascii = 8'h4D; // M --
      10'b11_10_00_00_00: ascii = 8'h4E; // N -.
      10'b11_11_11_00_00: ascii = 8'h4F; // O ---
      10'b10_11_11_10_00: ascii = 8'h50; // P .--.
      10'b11_11_10_11_00: ascii = 8'h51; // Q --.-
      10'b10_11_10_00_00: ascii = 8'h52; // R .-.
      10'b10_10_10_00_00: ascii = 8'h53; // S ...
      10'b11_00_00_00_00: ascii = 8'h54; // T -
      10'b10_10_11_00_00: ascii = 8'h55; // U ..-
      10'b10_10_10_11_00: ascii = 8'h56; // V ...-
      10'b10_11_11_00_00: ascii = 8'h57; // W .--
      10'b11_10_10_11_00: ascii = 8'h58; // X -..-
      10'b11_10_11_11_00: ascii = 8'h59; // Y -.--
      10'b11_11_10_10_00: ascii = 8'h5A; // Z --..
      10'b11_11_11_11_11: ascii = 8'h30; // 0 -----
      10'b10_11_11_11_11: ascii = 8'h31; // 1 .----
      10'b10_10_11_11_11: ascii = 8'h32; // 2 ..---
      10'b10_10_10_11_11: ascii = 8'h33; // 3 ...--
      10'b10_10_10_10_11: ascii = 8'h34; // 4 ....-
      10'b10_10_10_10_10: ascii = 8'h35; // 5 .....
      10'b11_10_10_10_10: ascii = 8'h36; // 6 -....
      10'b11_11_10_10_10: ascii = 8'h37; // 7 --...
      10'b11_11_11_10_10: ascii = 8'h38; // 8 ---..
      10'b11_11_11_11_10: ascii = 8'h39; // 9 ----.
      default: begin
        ascii = ASCII_NUL;
        err   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/morse_stream_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_stream_decoder                                         |
// | Description : Accepts Morse symbols over a valid/ready handshake,          |
// |               assembles letters, decodes them and queues {err, ascii}      |
// |               entries in an output FIFO.                                   |
// | Ports       : clk, rst_n (async, active low)                               |
// |               sym_valid/sym_ready/sym_code[1:0] - symbol input             |
// |               char_valid/char_ready/char_data[7:0]/char_err - FIFO head    |
// |               fifo_count - occupied entries; overflow - sticky flag        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic [1:0]                    sym_code,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic [7:0]                    char_data,
  output logic                          char_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int SR_W   = 2 * MAX_SYMBOLS;
  localparam int CNT_W  = $clog2(MAX_SYMBOLS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_SYMBOLS);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

  // State registers
  state_e              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic                ovf_letter_q, ovf_letter_d;
  logic                overflow_q, overflow_d;
  logic                last_was_space_q, last_was_space_d;
  logic                pend_space_q, pend_space_d;
  logic                ready_en_q, ready_en_d;

  // FIFO registers: entry = {err, ascii}
  logic [8:0]          mem_q [FIFO_DEPTH];
  logic [8:0]          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                sym_fire;
  logic                pop;
  logic                push;
  logic                push_ok;
  logic [8:0]          push_entry;
  logic [SR_W-1:0]     slot_bits;
  logic [7:0]          lut_ascii;
  logic                lut_err;
  logic                tail_nz;
  logic                emit_err;
  logic [8:0]          head;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // ready_en_q holds sym_ready low through the reset cycle
  assign sym_ready = ready_en_q && (state_q == ST_COLLECT) && !fifo_full;
  assign sym_fire  = sym_valid && sym_ready;
  assign pop       = char_ready && !fifo_empty;

  // New symbol positioned at slot sym_cnt (slot 0 in the MSBs)
  assign slot_bits = {sym_code, {(SR_W-2){1'b0}}} >> {sym_cnt_q, 1'b0};

  morse_lut u_lut (
    .code  (sr_q[SR_W-1 -: 10]),
    .ascii (lut_ascii),
    .err   (lut_err)
  );

  // Symbols beyond the fifth can never form a valid code
  if (MAX_SYMBOLS > 5) begin : g_tail
    assign tail_nz = |sr_q[SR_W-11:0];
  end else begin : g_no_tail
    assign tail_nz = 1'b0;
  end

  assign emit_err = lut_err || ovf_letter_q || tail_nz;

  always_comb begin
    state_d          = state_q;
    sr_d             = sr_q;
    sym_cnt_d        = sym_cnt_q;
    ovf_letter_d     = ovf_letter_q;
    overflow_d       = overflow_q;
    last_was_space_d = last_was_space_q;
    pend_space_d     = pend_space_q;
    ready_en_d       = 1'b1;
    push             = 1'b0;
    push_entry       = 9'd0;

    case (state_q)
      ST_COLLECT: begin
        if (sym_fire) begin
          case (sym_code)
            SYM_DOT, SYM_DASH: begin
              if (sym_cnt_q < MAX_CNT) begin
                sr_d      = sr_q | slot_bits;
                sym_cnt_d = sym_cnt_q + CNT_W'(1);
              end else begin
                ovf_letter_d = 1'b1;
                overflow_d   = 1'b1;
              end
            end
            SYM_LGAP: begin
              if (sym_cnt_q != '0) state_d = ST_EMIT_CHAR;
            end
            SYM_WGAP: begin
              if (sym_cnt_q != '0) begin
                state_d      = ST_EMIT_CHAR;
                pend_space_d = 1'b1;
              end else if (!last_was_space_q) begin
                state_d = ST_EMIT_SPACE;
              end
            end
            default: begin
            end
          endcase
        end
      end

      ST_EMIT_CHAR: begin
        // FIFO cannot be full here: the gap was only accepted with room free
        push             = 1'b1;
        push_entry       = {emit_err, emit_err ? ASCII_NUL : lut_ascii};
        sr_d             = '0;
        sym_cnt_d        = '0;
        ovf_letter_d     = 1'b0;
        last_was_space_d = 1'b0;
        state_d          = pend_space_q ? ST_EMIT_SPACE : ST_COLLECT;
      end

      ST_EMIT_SPACE: begin
        if (!fifo_full) begin
          push             = 1'b1;
          push_entry       = {1'b0, ASCII_SPACE};
          last_was_space_d = 1'b1;
          pend_space_d     = 1'b0;
          state_d          = ST_COLLECT;
        end
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  // FIFO bookkeeping; a pop frees the slot so a push into a full FIFO is legal
  always_comb begin
    push_ok  = push && (!fifo_full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - FCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_COLLECT;
      sr_q             <= '0;
      sym_cnt_q        <= '0;
      ovf_letter_q     <= 1'b0;
      overflow_q       <= 1'b0;
      last_was_space_q <= 1'b1;
      pend_space_q     <= 1'b0;
      ready_en_q       <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'd0;
    end else begin
      state_q          <= state_d;
      sr_q             <= sr_d;
      sym_cnt_q        <= sym_cnt_d;
      ovf_letter_q     <= ovf_letter_d;
      overflow_q       <= overflow_d;
      last_was_space_q <= last_was_space_d;
      pend_space_q     <= pend_space_d;
      ready_en_q       <= ready_en_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      mem_q            <= mem_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign char_valid = !fifo_empty;
  assign char_data  = char_valid ? head[7:0] : ASCII_NUL;
  assign char_err   = char_valid && head[8];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_stream_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_morse_stream_decoder                                      |
// | Description : Directed self-checking bench for morse_stream_decoder.       |
// |               Expected FIFO entries are queued as letters are sent and     |
// |               compared as the consumer pops them.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_morse_stream_decoder;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_code = SYM_LGAP;
  logic       char_ready = 1'b0;
  logic       sym_ready;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_err;
  logic [2:0] fifo_count;
  logic       overflow;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] exp_q [$];

  morse_stream_decoder #(
    .MAX_SYMBOLS (5),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_code   (sym_code),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_err   (char_err),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one symbol; returns at the negedge after the accepting edge
  task automatic send_sym(input logic [1:0] c);
    sym_valid = 1'b1;
    sym_code  = c;
    for (int i = 0; i < 50 && !sym_ready; i++) @(negedge clk);
    check("sym_accept", 32'(sym_ready), 32'd1);
    if (sym_ready) @(negedge clk);
    sym_valid = 1'b0;
    sym_code  = SYM_LGAP;
  endtask

  task automatic send_letter(input string s);
    for (int i = 0; i < s.len(); i++)
      send_sym((s[i] == 8'h2E) ? SYM_DOT : SYM_DASH);
    send_sym(SYM_LGAP);
  endtask

  task automatic expect_char(input logic [7:0] c, input logic e);
    exp_q.push_back({e, c});
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] exp;
    for (int i = 0; i < 50 && !char_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 32'(char_valid), 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    check(tag, 32'({char_err, char_data}), 32'(exp));
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sym_ready", 32'(sym_ready), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_char", 32'({char_err, char_data}), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(sym_ready), 32'd1);

    // Pop on empty FIFO is ignored
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
    check("empty_pop_count", 32'(fifo_count), 32'd0);

    // 1: ".-" -> A, one cycle after the gap is accepted
    expect_char(8'h41, 1'b0);
    send_sym(SYM_DOT);
    send_sym(SYM_DASH);
    send_sym(SYM_LGAP);
    check("t1_valid_at_N", 32'(char_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_at_N1", 32'(char_valid), 32'd1);
    pop_check("t1_A");
    check("t1_count", 32'(fifo_count), 32'd0);

    // 2: X then 1, in order
    expect_char(8'h58, 1'b0);
    expect_char(8'h31, 1'b0);
    send_letter("-..-");
    send_letter(".----");
    pop_check("t2_X");
    pop_check("t2_1");

    // 3: overlong letter, then a good letter; overflow stays set
    expect_char(8'h00, 1'b1);
    send_letter("......");
    pop_check("t3_ovf_entry");
    check("t3_overflow", 32'(overflow), 32'd1);
    expect_char(8'h41, 1'b0);
    send_letter(".-");
    pop_check("t3_A");
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: "..." wgap wgap "-" gap -> S, space, T
    expect_char(8'h53, 1'b0);
    expect_char(8'h20, 1'b0);
    expect_char(8'h54, 1'b0);
    send_sym(SYM_DOT);
    send_sym(SYM_DOT);
    send_sym(SYM_DOT);
    send_sym(SYM_WGAP);
    send_sym(SYM_WGAP);
    send_letter("-");
    @(negedge clk);
    check("t4_count", 32'(fifo_count), 32'd3);
    pop_check("t4_S");
    pop_check("t4_space");
    pop_check("t4_T");

    // 5: fill FIFO, back-pressure, then drain with push+pop in one cycle
    expect_char(8'h45, 1'b0);
    expect_char(8'h54, 1'b0);
    expect_char(8'h49, 1'b0);
    expect_char(8'h4D, 1'b0);
    send_letter(".");
    send_letter("-");
    send_letter("..");
    send_letter("--");
    @(negedge clk);
    check("t5_full_count", 32'(fifo_count), 32'd4);
    check("t5_full_ready", 32'(sym_ready), 32'd0);
    sym_valid = 1'b1;
    sym_code  = SYM_DOT;
    repeat (3) @(negedge clk);
    check("t5_held_ready", 32'(sym_ready), 32'd0);
    check("t5_held_count", 32'(fifo_count), 32'd4);
    pop_check("t5_E");
    check("t5_after_pop", 32'(fifo_count), 32'd3);
    send_sym(SYM_DOT);
    send_sym(SYM_DASH);
    expect_char(8'h41, 1'b0);
    send_sym(SYM_LGAP);
    pop_check("t5_T");
    check("t5_push_pop_count", 32'(fifo_count), 32'd3);
    pop_check("t5_I");
    pop_check("t5_M");
    pop_check("t5_A");
    check("t5_drained", 32'(fifo_count), 32'd0);

    // 6: async reset mid-letter discards everything
    send_letter(".");
    @(negedge clk);
    check("t6_pre_valid", 32'(char_valid), 32'd1);
    send_sym(SYM_DOT);
    send_sym(SYM_DASH);
    send_sym(SYM_DOT);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(char_valid), 32'd0);
    check("t6_rst_char", 32'({char_err, char_data}), 32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_overflow", 32'(overflow), 32'd0);
    check("t6_rst_ready", 32'(sym_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_char(8'h45, 1'b0);
    send_letter(".");
    pop_check("t6_E");
    @(negedge clk);
    check("t6_final_count", 32'(fifo_count), 32'd0);
    check("t6_final_valid", 32'(char_valid), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
